// File: rtl/ps2_scancode_decoder_if.sv
// Byte handshake from the ps2_keyboard FIFO plus the decoded key-event bundle.
// The slave modport is the decoder; the master modport is the FIFO/consumer side.
interface ps2_scancode_decoder_if #(
  parameter int unsigned CNT_W = 8
);
  logic [7:0]       ps2_data;
  logic             ps2_ready;
  logic             ps2_overflow;
  logic             nextdata_n;
  logic             key_valid;
  logic [7:0]       key_code;
  logic             key_ext;
  logic             key_break;
  logic             key_repeat;
  logic             key_held;
  logic [CNT_W-1:0] key_cnt;
  logic             err_ovf;
  logic [7:0]       ascii;

  modport master (
    output ps2_data, ps2_ready, ps2_overflow,
    input  nextdata_n, key_valid, key_code, key_ext, key_break, key_repeat,
    input  key_held, key_cnt, err_ovf, ascii
  );

  modport slave (
    input  ps2_data, ps2_ready, ps2_overflow,
    output nextdata_n, key_valid, key_code, key_ext, key_break, key_repeat,
    output key_held, key_cnt, err_ovf, ascii
  );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Pops bytes from the ps2_keyboard FIFO, resolves E0/F0 prefixes and emits key events.
// Optional PS2_ASCII_EN: shift tracking and a scan-code to ASCII translation on make events.
module ps2_scancode_decoder #(
  parameter int unsigned CNT_W         = 8,
  parameter bit          IGNORE_REPEAT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  ps2_scancode_decoder_if.slave bus
);
  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_LSHFT = 8'h12;
  localparam logic [7:0] CODE_RSHFT = 8'h59;

  typedef enum logic [1:0] {S_IDLE, S_POP, S_DEC} state_t;

  state_t           state;
  logic [7:0]       byte_r;
  logic             ext_pend;
  logic             brk_pend;
  logic [8:0]       held_key;
  logic             nextdata_n_r;
  logic             key_valid_r;
  logic [7:0]       key_code_r;
  logic             key_ext_r;
  logic             key_break_r;
  logic             key_repeat_r;
  logic             key_held_r;
  logic [CNT_W-1:0] key_cnt_r;
  logic             err_ovf_r;

  // Status bytes from the keyboard carry no key information unless a prefix is pending.
  logic discard_c;
  logic match_c;
  logic repeat_c;
  assign discard_c = !ext_pend && !brk_pend &&
                     (byte_r inside {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hFE});
  assign match_c   = (held_key == {ext_pend, byte_r});
  assign repeat_c  = key_held_r && match_c;

`ifdef PS2_ASCII_EN
  logic       shift_r;
  logic [7:0] ascii_r;
  logic [7:0] ascii_c;

  always_comb begin
    ascii_c = 8'h00;
    case (byte_r)
      8'h1C: ascii_c = "a";  8'h32: ascii_c = "b";  8'h21: ascii_c = "c";  8'h23: ascii_c = "d";
      8'h24: ascii_c = "e";  8'h2B: ascii_c = "f";  8'h34: ascii_c = "g";  8'h33: ascii_c = "h";
      8'h43: ascii_c = "i";  8'h3B: ascii_c = "j";  8'h42: ascii_c = "k";  8'h4B: ascii_c = "l";
      8'h3A: ascii_c = "m";  8'h31: ascii_c = "n";  8'h44: ascii_c = "o";  8'h4D: ascii_c = "p";
      8'h15: ascii_c = "q";  8'h2D: ascii_c = "r";  8'h1B: ascii_c = "s";  8'h2C: ascii_c = "t";
      8'h3C: ascii_c = "u";  8'h2A: ascii_c = "v";  8'h1D: ascii_c = "w";  8'h22: ascii_c = "x";
      8'h35: ascii_c = "y";  8'h1A: ascii_c = "z";
      8'h45: ascii_c = "0";  8'h16: ascii_c = "1";  8'h1E: ascii_c = "2";  8'h26: ascii_c = "3";
      8'h25: ascii_c = "4";  8'h2E: ascii_c = "5";  8'h36: ascii_c = "6";  8'h3D: ascii_c = "7";
      8'h3E: ascii_c = "8";  8'h46: ascii_c = "9";
      8'h29: ascii_c = 8'h20;
      8'h5A: ascii_c = 8'h0D;
      default: ascii_c = 8'h00;
    endcase
    // Only letters change case with shift.
    if (shift_r && (ascii_c >= "a") && (ascii_c <= "z")) ascii_c = ascii_c - 8'h20;
  end

  assign bus.ascii = ascii_r;
`else
  assign bus.ascii = 8'h00;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      byte_r       <= 8'h00;
      ext_pend     <= 1'b0;
      brk_pend     <= 1'b0;
      held_key     <= 9'h000;
      nextdata_n_r <= 1'b1;
      key_valid_r  <= 1'b0;
      key_code_r   <= 8'h00;
      key_ext_r    <= 1'b0;
      key_break_r  <= 1'b0;
      key_repeat_r <= 1'b0;
      key_held_r   <= 1'b0;
      key_cnt_r    <= '0;
      err_ovf_r    <= 1'b0;
`ifdef PS2_ASCII_EN
      shift_r      <= 1'b0;
      ascii_r      <= 8'h00;
`endif
    end else begin
      key_valid_r <= 1'b0;
      if (bus.ps2_overflow) err_ovf_r <= 1'b1;

      case (state)
        S_IDLE: begin
          if (bus.ps2_ready) begin
            byte_r       <= bus.ps2_data;
            nextdata_n_r <= 1'b0;
            state        <= S_POP;
          end
        end
        S_POP: begin
          nextdata_n_r <= 1'b1;
          state        <= S_DEC;
        end
        S_DEC: begin
          state <= S_IDLE;
          if (byte_r == CODE_EXT) begin
            ext_pend <= 1'b1;
          end else if (byte_r == CODE_BRK) begin
            brk_pend <= 1'b1;
          end else if (!discard_c) begin
            key_valid_r <= 1'b1;
            key_code_r  <= byte_r;
            key_ext_r   <= ext_pend;
            key_break_r <= brk_pend;
            ext_pend    <= 1'b0;
            brk_pend    <= 1'b0;
            if (brk_pend) begin
              // Releasing an untracked key leaves the held key alone.
              key_repeat_r <= 1'b0;
              if (match_c) key_held_r <= 1'b0;
            end else begin
              key_repeat_r <= repeat_c;
              if (!repeat_c || !IGNORE_REPEAT) key_cnt_r <= key_cnt_r + CNT_W'(1);
              held_key   <= {ext_pend, byte_r};
              key_held_r <= 1'b1;
            end
`ifdef PS2_ASCII_EN
            ascii_r <= brk_pend ? 8'h00 : ascii_c;
            if (!ext_pend && ((byte_r == CODE_LSHFT) || (byte_r == CODE_RSHFT)))
              shift_r <= !brk_pend;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.nextdata_n = nextdata_n_r;
  assign bus.key_valid  = key_valid_r;
  assign bus.key_code   = key_code_r;
  assign bus.key_ext    = key_ext_r;
  assign bus.key_break  = key_break_r;
  assign bus.key_repeat = key_repeat_r;
  assign bus.key_held   = key_held_r;
  assign bus.key_cnt    = key_cnt_r;
  assign bus.err_ovf    = err_ovf_r;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: acts as the ps2_keyboard FIFO, checks events
// against a directed table and a prefix/held-key reference model.
module tb_ps2_scancode_decoder;
  localparam int unsigned CNT_W         = 8;
  localparam bit          IGNORE_REPEAT = 1'b1;
`ifdef PS2_ASCII_EN
  localparam bit ASCII_EN = 1'b1;
`else
  localparam bit ASCII_EN = 1'b0;
`endif

  localparam logic [7:0] LET_CODES [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
    8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIG_CODES [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] POOL [10] = '{
    8'h1C, 8'h32, 8'h12, 8'h59, 8'h75, 8'h29, 8'h5A, 8'h45, 8'h16, 8'h1A};
  localparam logic [7:0] STATUS [6] = '{8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hFE};

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
    logic       held;
    logic [7:0] cnt;
    logic [7:0] asc;
  } ev_t;

  typedef struct {
    logic [7:0] b;
    bit         ev;
    ev_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  ps2_scancode_decoder_if #(.CNT_W(CNT_W)) bus ();
  ps2_scancode_decoder #(.CNT_W(CNT_W), .IGNORE_REPEAT(IGNORE_REPEAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         pops  = 0;
  logic [7:0] fifo_q[$];
  ev_t        got_q[$];
  ev_t        exp_q[$];

  // Reference model state: pending prefixes, tracked key, counter, shift.
  bit         m_ext, m_brk, m_held, m_shift;
  logic [8:0] m_key;
  int         m_cnt;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_ascii(input logic [7:0] code, input bit shift);
    for (int i = 0; i < 26; i++) if (LET_CODES[i] == code) return 8'((shift ? 65 : 97) + i);
    for (int i = 0; i < 10; i++) if (DIG_CODES[i] == code) return 8'(48 + i);
    if (code == 8'h29) return 8'h20;
    if (code == 8'h5A) return 8'h0D;
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_held = 0; m_shift = 0; m_key = '0; m_cnt = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit         is_status;
    bit         rep;
    logic [7:0] asc;
    is_status = 0;
    foreach (STATUS[i]) if (STATUS[i] == b) is_status = 1;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (!(is_status && !m_ext && !m_brk)) begin
      rep = 0;
      asc = 8'h00;
      if (m_brk) begin
        if (m_key == {m_ext, b}) m_held = 0;
      end else begin
        rep = m_held && (m_key == {m_ext, b});
        if (!rep || !IGNORE_REPEAT) m_cnt = (m_cnt + 1) % (1 << CNT_W);
        m_held = 1;
        m_key  = {m_ext, b};
        if (ASCII_EN) asc = ref_ascii(b, m_shift);
      end
      exp_q.push_back('{b, m_ext, m_brk, rep, m_held, 8'(m_cnt), asc});
      if (ASCII_EN && !m_ext && (b == 8'h12 || b == 8'h59)) m_shift = !m_brk;
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic refresh();
    bus.ps2_ready = (fifo_q.size() != 0);
    bus.ps2_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic feed(input logic [7:0] b);
    model_byte(b);
    fifo_q.push_back(b);
    refresh();
  endtask

  // One clock: sample at negedge, capture events, and pop on a low strobe.
  task automatic tick();
    @(negedge clk);
    if (bus.key_valid === 1'b1)
      got_q.push_back('{bus.key_code, bus.key_ext, bus.key_break, bus.key_repeat,
                        bus.key_held, 8'(bus.key_cnt), bus.ascii});
    if (bus.nextdata_n === 1'b0) begin
      pops++;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    refresh();
  endtask

  task automatic run_until_idle(input int budget);
    int idle = 0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (fifo_q.size() == 0) idle++; else idle = 0;
      if (idle >= 5) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL drain_timeout: %0d bytes left, expected 0", fifo_q.size());
  endtask

  task automatic compare_events(input string name);
    check({name, " event count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() != 0 && exp_q.size() != 0)
      check({name, " event"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.ps2_overflow = 1'b0;
    fifo_q.delete();
    refresh();
    got_q.delete();
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic vec_t mk(input logic [7:0] b, input bit ev, input bit ext, input bit brk,
                              input bit rep, input bit held, input logic [7:0] cnt,
                              input logic [7:0] asc);
    vec_t v;
    v.b  = b;
    v.ev = ev;
    v.e  = '{b, ext, brk, rep, held, cnt, ASCII_EN ? asc : 8'h00};
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vt[$];
    int   r;
    bit   seen;

    // Reset held with a byte already waiting in the FIFO.
    rst = 1'b0;
    bus.ps2_overflow = 1'b0;
    model_reset();
    fifo_q.push_back(8'h1C);
    refresh();
    repeat (3) @(negedge clk);
    check("reset nextdata_n", 64'(bus.nextdata_n), 64'(1));
    check("reset outputs", 64'({bus.key_valid, bus.key_code, bus.key_ext, bus.key_break,
                                bus.key_repeat, bus.key_held, bus.key_cnt, bus.err_ovf,
                                bus.ascii}), 64'(0));
    rst = 1'b1;
    model_byte(8'h1C);
    tick();
    check("pop after release", 64'(bus.nextdata_n), 64'(0));
    run_until_idle(40);
    compare_events("first press");

    // Directed table, one byte per row.
    do_reset();
    vt.push_back(mk(8'h1C, 1, 0, 0, 0, 1, 8'd1, 8'h61));
    vt.push_back(mk(8'hF0, 0, 0, 0, 0, 0, 8'd0, 8'h00));
    vt.push_back(mk(8'h1C, 1, 0, 1, 0, 0, 8'd1, 8'h00));
    vt.push_back(mk(8'hE0, 0, 0, 0, 0, 0, 8'd0, 8'h00));
    vt.push_back(mk(8'h75, 1, 1, 0, 0, 1, 8'd2, 8'h00));
    vt.push_back(mk(8'hE0, 0, 0, 0, 0, 0, 8'd0, 8'h00));
    vt.push_back(mk(8'hF0, 0, 0, 0, 0, 0, 8'd0, 8'h00));
    vt.push_back(mk(8'h75, 1, 1, 1, 0, 0, 8'd2, 8'h00));
    vt.push_back(mk(8'h1C, 1, 0, 0, 0, 1, 8'd3, 8'h61));
    vt.push_back(mk(8'h1C, 1, 0, 0, 1, 1, 8'd3, 8'h61));
    vt.push_back(mk(8'h1C, 1, 0, 0, 1, 1, 8'd3, 8'h61));
    vt.push_back(mk(8'h1C, 1, 0, 0, 1, 1, 8'd3, 8'h61));
    vt.push_back(mk(8'hF0, 0, 0, 0, 0, 0, 8'd0, 8'h00));
    vt.push_back(mk(8'h1C, 1, 0, 1, 0, 0, 8'd3, 8'h00));
    vt.push_back(mk(8'hAA, 0, 0, 0, 0, 0, 8'd0, 8'h00));
    vt.push_back(mk(8'hFA, 0, 0, 0, 0, 0, 8'd0, 8'h00));
    vt.push_back(mk(8'hF0, 0, 0, 0, 0, 0, 8'd0, 8'h00));
    vt.push_back(mk(8'hAA, 1, 0, 1, 0, 0, 8'd3, 8'h00));
    vt.push_back(mk(8'h12, 1, 0, 0, 0, 1, 8'd4, 8'h00));
    vt.push_back(mk(8'h1C, 1, 0, 0, 0, 1, 8'd5, 8'h41));
    vt.push_back(mk(8'hF0, 0, 0, 0, 0, 0, 8'd0, 8'h00));
    vt.push_back(mk(8'h12, 1, 0, 1, 0, 1, 8'd5, 8'h00));
    vt.push_back(mk(8'h1C, 1, 0, 0, 1, 1, 8'd5, 8'h61));
    vt.push_back(mk(8'h29, 1, 0, 0, 0, 1, 8'd6, 8'h20));
    vt.push_back(mk(8'h5A, 1, 0, 0, 0, 1, 8'd7, 8'h0D));
    vt.push_back(mk(8'h45, 1, 0, 0, 0, 1, 8'd8, 8'h30));
    pops = 0;
    for (int i = 0; i < vt.size(); i++) begin
      fifo_q.push_back(vt[i].b);
      refresh();
      run_until_idle(40);
      if (vt[i].ev) begin
        check($sformatf("vec[%0d] valid", i), 64'(got_q.size()), 64'(1));
        if (got_q.size() != 0) check($sformatf("vec[%0d] fields", i), 64'(got_q[0]), 64'(vt[i].e));
      end else begin
        check($sformatf("vec[%0d] no event", i), 64'(got_q.size()), 64'(0));
      end
      got_q.delete();
    end
    check("table pop count", 64'(pops), 64'(vt.size()));

    // Reset while the pop strobe is low drops the pending E0 prefix.
    do_reset();
    feed(8'hE0);
    run_until_idle(40);
    compare_events("prefix only");
    fifo_q.push_back(8'h1C);
    refresh();
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = (bus.nextdata_n === 1'b0);
    end
    check("strobe seen before reset", 64'(seen), 64'(1));
    rst = 1'b0;
    #1;
    check("async strobe release", 64'(bus.nextdata_n), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    model_byte(8'h1C);
    run_until_idle(40);
    compare_events("after mid reset");

    // Typematic burst, bytes back to back in the FIFO.
    do_reset();
    repeat (4) feed(8'h1C);
    feed(8'hF0);
    feed(8'h1C);
    run_until_idle(200);
    compare_events("typematic");
    check("typematic cnt", 64'(bus.key_cnt), IGNORE_REPEAT ? 64'(1) : 64'(4));

    // Sticky overflow.
    check("err_ovf before", 64'(bus.err_ovf), 64'(0));
    @(negedge clk);
    bus.ps2_overflow = 1'b1;
    @(negedge clk);
    bus.ps2_overflow = 1'b0;
    @(negedge clk);
    check("err_ovf set", 64'(bus.err_ovf), 64'(1));
    feed(8'h32);
    feed(8'hAA);
    run_until_idle(100);
    compare_events("traffic after overflow");
    check("err_ovf sticky", 64'(bus.err_ovf), 64'(1));

    // 256 press/release pairs wrap the counter back to zero.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      if (i >= 127) feed(8'hE0);
      feed(8'((i % 127) + 1));
      if (i >= 127) feed(8'hE0);
      feed(8'hF0);
      feed(8'((i % 127) + 1));
    end
    run_until_idle(20000);
    compare_events("counter wrap");
    check("key_cnt wrapped", 64'(bus.key_cnt), 64'(0));

    // Random byte streams against the reference model.
    do_reset();
    for (int chunk = 0; chunk < 15; chunk++) begin
      for (int k = 0; k < 20; k++) begin
        r = int'($urandom_range(0, 99));
        if (r < 15)      feed(8'hE0);
        else if (r < 30) feed(8'hF0);
        else if (r < 38) feed(STATUS[$urandom_range(0, 5)]);
        else if (r < 75) feed(POOL[$urandom_range(0, 9)]);
        else             feed(8'($urandom_range(1, 8'hDF)));
      end
      run_until_idle(400);
      compare_events($sformatf("random chunk %0d", chunk));
      check($sformatf("random chunk %0d held", chunk), 64'(bus.key_held), 64'(m_held));
      check($sformatf("random chunk %0d cnt", chunk), 64'(bus.key_cnt), 64'(m_cnt));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
